// File: rtl/tdm_demux4_pkg.sv
// Shared types for the 4-slot TDM demultiplexer: slot index, frame size and FSM states.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FIRST_SLOT = slot_t'(0);
  localparam slot_t LAST_SLOT  = slot_t'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial slot stream in, four parallel channels plus status out.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_valid;
  logic             sync_err;
  logic             locked;

  modport master (
    output in_valid, in_sync, in_data,
    input  d0, d1, d2, d3, out_valid, sync_err, locked
  );

  modport slave (
    input  in_valid, in_sync, in_data,
    output d0, d1, d2, d3, out_valid, sync_err, locked
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot position counter: clear, load-to-1 (new frame), increment with natural 3->0 wrap.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_inc,
  input  logic  i_load1,
  input  logic  i_clr,
  output slot_t o_cnt,
  output logic  o_last_c
);

  slot_t r_cnt;

  // Clear has priority so an error beat always leaves the counter at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= FIRST_SLOT;
    end else if (i_clr) begin
      r_cnt <= FIRST_SLOT;
    end else if (i_load1) begin
      r_cnt <= slot_t'(1);
    end else if (i_inc) begin
      r_cnt <= r_cnt + slot_t'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_last_c = (r_cnt == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: frames slots on in_sync, shadows slots 0..2 and
// publishes all four channels at once when slot 3 arrives.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow [NUM_SLOTS-1];
  logic [WIDTH-1:0] r_d      [NUM_SLOTS];
  logic             r_out_valid;
  logic             r_sync_err;
  logic             r_locked;

  slot_t            w_cnt;
  logic             w_last;
  logic             w_inc;
  logic             w_load1;
  logic             w_clr;
  logic             w_in_lock;

  assign w_in_lock = (r_state == LOCK);

  // Any accepted sync beat starts a frame; unsynced beats advance only a locked, mid-frame counter.
  assign w_load1 = bus.in_valid && bus.in_sync;
  assign w_inc   = bus.in_valid && !bus.in_sync && w_in_lock && (w_cnt != FIRST_SLOT);
  assign w_clr   = bus.in_valid && !bus.in_sync && w_in_lock && (w_cnt == FIRST_SLOT);

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_inc),
    .i_load1  (w_load1),
    .i_clr    (w_clr),
    .o_cnt    (w_cnt),
    .o_last_c (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_locked    <= 1'b0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS) - 1; i++) r_shadow[i] <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++)     r_d[i]      <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          HUNT: begin
            if (bus.in_sync) begin
              r_shadow[0] <= bus.in_data;
              r_state     <= LOCK;
              r_locked    <= 1'b1;
            end
          end
          LOCK: begin
            if (bus.in_sync) begin
              // A sync anywhere but slot 0 aborts the partial frame and restarts on this beat.
              r_shadow[0] <= bus.in_data;
              if (w_cnt != FIRST_SLOT) r_sync_err <= 1'b1;
            end else if (w_cnt == FIRST_SLOT) begin
              r_sync_err <= 1'b1;
              r_state    <= HUNT;
              r_locked   <= 1'b0;
            end else if (w_last) begin
              r_d[0]      <= r_shadow[0];
              r_d[1]      <= r_shadow[1];
              r_d[2]      <= r_shadow[2];
              r_d[3]      <= bus.in_data;
              r_out_valid <= 1'b1;
            end else if (w_cnt == slot_t'(1)) begin
              r_shadow[1] <= bus.in_data;
            end else begin
              r_shadow[2] <= bus.in_data;
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.d0        = r_d[0];
  assign bus.d1        = r_d[1];
  assign bus.d2        = r_d[2];
  assign bus.d3        = r_d[3];
  assign bus.out_valid = r_out_valid;
  assign bus.sync_err  = r_sync_err;
  assign bus.locked    = r_locked;

endmodule
